secuenciador_tiempos: RTL and testbench

//  Timing-phase generator for the control unit. A parametrised step counter drives a one-hot

---
 rtl/secuenciador_tiempos_pkg.sv | 28 ++
 rtl/secuenciador_tiempos_decodificador_n.sv | 18 +
 rtl/secuenciador_tiempos.sv | 102 ++++++++++
 tb/tb_secuenciador_tiempos.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_tiempos_pkg.sv
// Shared definitions for the timing-phase sequencer and the rest of the control unit.
// Holds the default counter geometry and the command-priority encoding.
// Contents: N_BITS_DEF, PASOS_DEF, cmd_e, sel_cmd().
package secuenciador_tiempos_pkg;

  // Default geometry shared with the control-unit top.
  localparam int N_BITS_DEF = 3;
  localparam int PASOS_DEF  = 2 ** N_BITS_DEF;

  // One command acts per edge. The encoding is ordered by priority, highest last.
  typedef enum logic [1:0] {
    CMD_NADA   = 2'd0,
    CMD_AVANZA = 2'd1,
    CMD_CARGA  = 2'd2,
    CMD_LIMPIA = 2'd3
  } cmd_e;

  // Collapse the command strobes into the single command that wins this edge.
  function automatic cmd_e sel_cmd(input logic limpia, input logic carga, input logic avanza);
    cmd_e c;
    if (limpia)      c = CMD_LIMPIA;
    else if (carga)  c = CMD_CARGA;
    else if (avanza) c = CMD_AVANZA;
    else             c = CMD_NADA;
    return c;
  endfunction

endpackage

// File: rtl/secuenciador_tiempos_decodificador_n.sv
// Purpose: N_BITS -> 2**N_BITS one-hot decoder with active-high disable.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output all-zero while dis=1.
// Ports: dis (disable), ent (code to decode), sal (one-hot or all-zero).
module decodificador_n #(
  parameter int N_BITS = 3
) (
  input  logic                 dis,
  input  logic [N_BITS-1:0]    ent,
  output logic [2**N_BITS-1:0] sal
);

  always_comb begin
    sal = '0;
    if (!dis) sal[ent] = 1'b1;
  end

endmodule

// File: rtl/secuenciador_tiempos.sv
// Purpose: step counter driving one-hot timing phases T0..T(PASOS-1) for microinstruction sequencing.
// Latency: commands at edge k show on paso/sal after edge k; fin high the cycle after a wrap; dis hits sal combinationally.
// Backpressure: none; dis freezes the count (limpia still acts) and blanks sal.
// Ports: clk, rst_n (async, active-low), dis, limpia, carga, ent, avanza, [retro], sal, paso, fin, err.
// Optional feature: define SECUENCIADOR_RETRO_EN to add the retro input (avanza counts down while retro=1).
module secuenciador_tiempos
  import secuenciador_tiempos_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int PASOS  = 2 ** N_BITS,
  parameter int INICIO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dis,
  input  logic                 limpia,
  input  logic                 carga,
  input  logic [N_BITS-1:0]    ent,
  input  logic                 avanza,
`ifdef SECUENCIADOR_RETRO_EN
  input  logic                 retro,
`endif
  output logic [2**N_BITS-1:0] sal,
  output logic [N_BITS-1:0]    paso,
  output logic                 fin,
  output logic                 err
);

  // Last valid step and the start step, sized to the counter so compares stay N_BITS wide.
  localparam logic [N_BITS-1:0] ULTIMO = N_BITS'(PASOS - 1);
  localparam logic [N_BITS-1:0] INI    = N_BITS'(INICIO);

  cmd_e              cmd;
  logic [N_BITS-1:0] paso_nxt;
  logic              fin_nxt;
  logic              err_nxt;
  logic              atras;

`ifdef SECUENCIADOR_RETRO_EN
  assign atras = retro;
`else
  assign atras = 1'b0;
`endif

  // dis masks carga/avanza but never limpia.
  assign cmd = sel_cmd(limpia, carga & ~dis, avanza & ~dis);

  always_comb begin
    paso_nxt = paso;
    fin_nxt  = 1'b0;
    err_nxt  = err;
    case (cmd)
      CMD_LIMPIA: begin
        paso_nxt = INI;
        err_nxt  = 1'b0;
      end
      CMD_CARGA: begin
        // Out-of-range loads are refused and flagged; the step holds.
        if (ent <= ULTIMO) paso_nxt = ent;
        else               err_nxt  = 1'b1;
      end
      CMD_AVANZA: begin
        // Explicit wrap compare so PASOS < 2**N_BITS never reaches unused steps.
        if (atras) begin
          if (paso == '0) begin
            paso_nxt = ULTIMO;
            fin_nxt  = 1'b1;
          end else begin
            paso_nxt = paso - 1'b1;
          end
        end else begin
          if (paso == ULTIMO) begin
            paso_nxt = '0;
            fin_nxt  = 1'b1;
          end else begin
            paso_nxt = paso + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paso <= INI;
      fin  <= 1'b0;
      err  <= 1'b0;
    end else begin
      paso <= paso_nxt;
      fin  <= fin_nxt;
      err  <= err_nxt;
    end
  end

  decodificador_n #(.N_BITS(N_BITS)) u_deco (
    .dis (dis),
    .ent (paso),
    .sal (sal)
  );

endmodule

// File: tb/tb_secuenciador_tiempos.sv
// Bench for secuenciador_tiempos with N_BITS=3, PASOS=6, INICIO=0.
// Directed scenarios followed by randomized commands against a behavioural model.
// Outputs are sampled 1 time unit after the rising edge; inputs change there too.
module tb_secuenciador_tiempos;

  localparam int NB = 3;
  localparam int NP = 6;
  localparam int NI = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dis = 1'b0;
  logic          limpia = 1'b0;
  logic          carga = 1'b0;
  logic [NB-1:0] ent = '0;
  logic          avanza = 1'b0;
  logic          retro = 1'b0;
  logic [7:0]    sal;
  logic [NB-1:0] paso;
  logic          fin;
  logic          err;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int m_paso = NI;
  int m_fin = 0;
  int m_err = 0;

  always #5 clk = ~clk;

  secuenciador_tiempos #(.N_BITS(NB), .PASOS(NP), .INICIO(NI)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dis    (dis),
    .limpia (limpia),
    .carga  (carga),
    .ent    (ent),
    .avanza (avanza),
`ifdef SECUENCIADOR_RETRO_EN
    .retro  (retro),
`endif
    .sal    (sal),
    .paso   (paso),
    .fin    (fin),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_sal;
    e_sal = dis ? 8'h00 : (8'h01 << m_paso);
    chk({tag, ".paso"}, 32'(paso), 32'(m_paso));
    chk({tag, ".sal"},  32'(sal),  32'(e_sal));
    chk({tag, ".fin"},  32'(fin),  32'(m_fin));
    chk({tag, ".err"},  32'(err),  32'(m_err));
  endtask

  // Model one rising edge from the command rules (modular arithmetic, priority order).
  task automatic model_edge();
    if (!rst_n) begin
      m_paso = NI; m_fin = 0; m_err = 0;
    end else if (limpia) begin
      m_paso = NI; m_err = 0; m_fin = 0;
    end else if (dis) begin
      m_fin = 0;
    end else if (carga) begin
      if (int'(ent) < NP) m_paso = int'(ent);
      else                m_err = 1;
      m_fin = 0;
    end else if (avanza) begin
`ifdef SECUENCIADOR_RETRO_EN
      if (retro) begin
        m_fin  = (m_paso == 0) ? 1 : 0;
        m_paso = (m_paso + NP - 1) % NP;
      end else
`endif
      begin
        m_fin  = (m_paso == NP - 1) ? 1 : 0;
        m_paso = (m_paso + 1) % NP;
      end
    end else begin
      m_fin = 0;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cmd(input logic l, input logic c, input logic a, input logic [NB-1:0] e);
    limpia = l; carga = c; avanza = a; ent = e;
  endtask

  initial begin
    // Reset held from time zero
    #1;
    check_all("reset");
    #12;
    rst_n = 1'b1;
    cmd(0, 0, 0, 0);
    tick("idle");

    // Wrap: six advances from 0, then one more cycle to see fin drop
    cmd(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) tick("wrap");
    cmd(0, 0, 0, 0);
    tick("wrap_after");

    // Load range and clear
    cmd(0, 1, 0, 3'd3); tick("load3");
    cmd(0, 1, 0, 3'd7); tick("load7_bad");
    cmd(0, 1, 0, 3'd6); tick("load6_bad");
    cmd(1, 0, 0, 0);    tick("clear");

    // Priority
    cmd(0, 1, 0, 3'd2); tick("prio_setup");
    cmd(1, 1, 1, 3'd4); tick("prio_all");
    cmd(0, 1, 1, 3'd4); tick("prio_load_adv");

    // Disable
    cmd(0, 1, 0, 3'd2); tick("dis_setup");
    cmd(0, 0, 0, 0);
    dis = 1'b1; #1;
    check_all("dis_comb");
    cmd(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick("dis_adv");
    cmd(0, 1, 0, 3'd5); tick("dis_load");
    cmd(0, 0, 0, 0);
    dis = 1'b0; #1;
    check_all("undis_comb");
    dis = 1'b1;
    cmd(1, 0, 0, 0); tick("dis_clear");
    dis = 1'b0;

`ifdef SECUENCIADOR_RETRO_EN
    retro = 1'b1;
    cmd(0, 0, 1, 0); tick("retro_wrap");
    tick("retro_step");
    retro = 1'b0;
`endif

    // Asynchronous reset mid-cycle with paso=4
    cmd(0, 1, 0, 3'd4); tick("areset_setup");
    cmd(0, 0, 0, 0);
    #2; rst_n = 1'b0; #1;
    m_paso = NI; m_fin = 0; m_err = 0;
    check_all("areset");
    #1; rst_n = 1'b1;
    tick("areset_after");

    // Randomized commands
    for (int i = 0; i < 400; i++) begin
      limpia = ($urandom_range(0, 15) == 0);
      carga  = ($urandom_range(0, 3) == 0);
      avanza = ($urandom_range(0, 1) == 0);
      ent    = NB'($urandom_range(0, 7));
      dis    = ($urandom_range(0, 7) == 0);
`ifdef SECUENCIADOR_RETRO_EN
      retro  = ($urandom_range(0, 3) == 0);
`endif
      #1;
      check_all("rnd_comb");
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; #1;
        m_paso = NI; m_fin = 0; m_err = 0;
        check_all("rnd_areset");
        rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
